regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the RV32 core, with a scoreboard. It provides NRD registered read ports, NWR write-back ports, write-to-read bypass, hardwired-zero x0 and a per-register busy bit, so decode can detect RAW hazards on in-flight results. It sits between decode/issue (reads, reservations) and write-back (writes, busy clear).

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers, power of two, ≥2; AW = $clog2(NREGS).
- NRD, 2: number of read ports, ≥1.
- NWR, 1: number of write ports, ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  per-port register index; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data, one cycle after rd_req.
- rd_busy  out  NRD  registered busy bit of the register read.
- rd_valid  out  NRD  high one cycle after rd_req[i].
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write index.
- wr_data  in  NWR*XLEN  write data.
- rsv_en  in  1  reserve a destination register (mark busy) at issue.
- rsv_addr  in  AW  register to reserve.

## Operation
- Storage: NREGS × XLEN array plus NREGS busy bits.
- Reset (rst_n low, asynchronous): every register is 0 and every busy bit is 0. rd_data, rd_busy and rd_valid are all 0.
- x0:
  - Writes to index 0 are discarded.
  - Reservations of index 0 are discarded.
  - Reads of index 0 always return data 0 and busy 0.
- Write: wr_en[j] with a nonzero wr_addr[j] stores wr_data[j] and clears busy[wr_addr[j]].
- Write conflict: if several ports write the same index in one cycle, the highest-numbered port wins.
- Reserve: rsv_en with a nonzero rsv_addr sets busy[rsv_addr].
- Reserve vs. clear: if a reserve and a write hit the same index in one cycle, the data is written and busy ends at 1, because the new producer wins.
- Read: rd_req[i] captures data and busy for rd_addr[i] into the port-i output registers.
- Bypass: if a write to the same nonzero index occurs in the same cycle as the read, the read returns the write data, applying the same port priority as the write conflict rule.
  - Reported busy = 0 if the index is written that cycle, unless it is also reserved that cycle; a same-cycle reserve gives busy = 1.
  - Otherwise reported busy is the stored bit.
- Hold: rd_data and rd_busy hold their previous values when rd_req[i] = 0. rd_valid[i] drops to 0.
- Read ports are independent. Any number of ports may read the same index in the same cycle.

## Timing
- Read latency: 1 cycle, with rd_valid/rd_data/rd_busy registered and no combinational path from inputs to outputs.
- Write latency: data is visible to a read issued in the same cycle (via bypass) and in every later cycle.
- Throughput: every port can accept one request per cycle, sustained.
- Busy set/clear takes effect at the edge; a read in the same cycle sees it through the bypass rules above.
- Reset assertion mid-operation clears all state and outputs immediately. The first request after deassertion is served normally.
- No backpressure: a consumer must sample the outputs in the rd_valid cycle.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - the AW helper function;
  - a typedef for a register index and a typedef for a register word.
- One sub-module, regfile_rport, one instance per read port. It implements the bypass mux, the priority select over the NWR write ports, the x0 masking and the output registers.
- The top level holds the array, the busy vector and the write/reserve logic. Target size is 150–300 lines total.

## Test plan
- Reset, then read x5 and x31 on ports 0/1 -> next cycle rd_valid=2'b11, rd_data = 0/0, rd_busy = 0/0.
- Write x3=0xDEADBEEF while port 0 reads x3 in the same cycle -> port 0 returns 0xDEADBEEF. A read of x3 one cycle later also returns 0xDEADBEEF.
- Write x0=0x12345678 and reserve x0, then read x0 -> data 0, busy 0.
- Reserve x7, then read x7 -> busy 1. Write x7=0x55 and reserve x7 in the same cycle -> a read returns 0x55 with busy 1. Write x7=0x66 alone -> a read returns busy 0 and data 0x66.
- With NWR=2: both ports write x9 (0xA, 0xB) in the same cycle -> x9 = 0xB, and a same-cycle read returns 0xB.
- Pulse rst_n low for half a cycle between reads of written x4 -> rd_valid drops immediately, and the next read of x4 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the multi-port integer register file:
//               default geometry, the index-width helper and the index/word
//               typedefs used by the register file and its users.
// Contents    : c_xlen_default  - default register width (32)
//               c_nregs_default - default register count (32)
//               calc_aw()       - index width for a given register count
//               reg_idx_t       - register index at default geometry
//               reg_word_t      - register word at default geometry
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_xlen_default  = 32;
    localparam int c_nregs_default = 32;

    // Index width for an array of n registers; n is a power of two >= 2.
    function automatic int calc_aw(input int n);
        return $clog2(n);
    endfunction

    typedef logic [$clog2(c_nregs_default)-1:0] reg_idx_t;
    typedef logic [c_xlen_default-1:0]          reg_word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rport
// Description : One registered read port of the register file. Selects
//               between the stored word/busy bit and a same-cycle write
//               (highest-numbered write port wins), forces x0 to zero and
//               registers data, busy and valid.
// Ports       : clk, rst_n          - clock, async active-low reset
//               rd_req, rd_addr     - read request and register index
//               rf_data, rf_busy    - stored word and busy bit at rd_addr
//               wr_en/addr/data     - all write-back ports (for bypass)
//               rsv_en, rsv_addr    - same-cycle reservation
//               rd_data/busy/valid  - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int XLEN = c_xlen_default,
    parameter int AW   = calc_aw(c_nregs_default),
    parameter int NWR  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic                 rf_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic                 rd_busy,
    output logic                 rd_valid
);

    logic            w_wr_hit;
    logic [XLEN-1:0] w_byp_data;
    logic            w_rsv_hit;
    logic [XLEN-1:0] w_nxt_data;
    logic            w_nxt_busy;

    // Scan ports in ascending order so the highest-numbered hit is the one
    // left standing, matching the write-conflict priority of the array.
    always_comb begin
        w_wr_hit   = 1'b0;
        w_byp_data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
                w_wr_hit   = 1'b1;
                w_byp_data = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    assign w_rsv_hit = rsv_en && (rsv_addr == rd_addr);

    // x0 masking dominates; a bypassed write clears busy unless the same
    // register is re-reserved this cycle (the new producer wins).
    always_comb begin
        w_nxt_data = rf_data;
        w_nxt_busy = rf_busy;
        if (rd_addr == '0) begin
            w_nxt_data = '0;
            w_nxt_busy = 1'b0;
        end else if (w_wr_hit) begin
            w_nxt_data = w_byp_data;
            w_nxt_busy = w_rsv_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= w_nxt_data;
                rd_busy <= w_nxt_busy;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port RV32 integer register file with a
//               per-register busy scoreboard. NRD registered read ports with
//               write-to-read bypass, NWR write-back ports, hardwired-zero x0
//               and a reservation port that marks destinations busy at issue.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               rd_req/rd_addr                - per-port read requests
//               rd_data/rd_busy/rd_valid      - registered read results
//               wr_en/wr_addr/wr_data         - write-back ports (clear busy)
//               rsv_en/rsv_addr               - destination reservation
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int NREGS = c_nregs_default,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD-1:0]       rd_req,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD-1:0]       rd_valid,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    // Later write ports overwrite earlier ones through NBA ordering, so the
    // highest-numbered port wins a conflict. The reserve is applied last so
    // that a same-cycle reserve leaves the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                    r_busy[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (rsv_en && (rsv_addr != '0)) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rport
            logic [AW-1:0] w_addr;
            assign w_addr = rd_addr[i*AW +: AW];

            regfile_rport #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR)
            ) u_rport (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_req   (rd_req[i]),
                .rd_addr  (w_addr),
                .rf_data  (r_regs[w_addr]),
                .rf_busy  (r_busy[w_addr]),
                .wr_en    (wr_en),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .rsv_en   (rsv_en),
                .rsv_addr (rsv_addr),
                .rd_data  (rd_data[i*XLEN +: XLEN]),
                .rd_busy  (rd_busy[i]),
                .rd_valid (rd_valid[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (NRD=2, NWR=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int c_aw = 5;

    logic          clk;
    logic          rst_n;
    logic [1:0]    rd_req;
    logic [9:0]    rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    rd_valid;
    logic [1:0]    wr_en;
    logic [9:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          rsv_en;
    logic [4:0]    rsv_addr;

    int n_cmp;
    int n_err;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input reg_word_t obs, input reg_word_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_req   = '0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int port, input logic [4:0] addr);
        rd_req[port]                 = 1'b1;
        rd_addr[port*c_aw +: c_aw]   = addr;
    endtask

    task automatic wr(input int port, input logic [4:0] addr, input logic [31:0] data);
        wr_en[port]                  = 1'b1;
        wr_addr[port*c_aw +: c_aw]   = addr;
        wr_data[port*32 +: 32]       = data;
    endtask

    task automatic rsv(input logic [4:0] addr);
        rsv_en   = 1'b1;
        rsv_addr = addr;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset_valid", 32'(rd_valid), 32'h0);
        check("reset_data0", rd_data[31:0], 32'h0);
        check("reset_busy",  32'(rd_busy), 32'h0);
        rst_n = 1'b1;

        // Freshly reset registers read as zero, not busy.
        rd(0, 5'd5); rd(1, 5'd31);
        tick(); clear_inputs();
        check("rd_fresh_valid", 32'(rd_valid), 32'h3);
        check("rd_fresh_data0", rd_data[31:0], 32'h0);
        check("rd_fresh_data1", rd_data[63:32], 32'h0);
        check("rd_fresh_busy",  32'(rd_busy), 32'h0);

        // Same-cycle write bypass, then a later read, with port-0 hold.
        wr(0, 5'd3, 32'hDEADBEEF); rd(0, 5'd3);
        tick(); clear_inputs();
        check("byp_x3_data", rd_data[31:0], 32'hDEADBEEF);
        check("byp_x3_busy", 32'(rd_busy[0]), 32'h0);
        rd(1, 5'd3);
        tick(); clear_inputs();
        check("later_x3_data", rd_data[63:32], 32'hDEADBEEF);
        check("later_valid",   32'(rd_valid), 32'h2);
        check("hold_data0",    rd_data[31:0], 32'hDEADBEEF);

        // x0: write and reserve discarded, read is always zero/not busy.
        wr(0, 5'd0, 32'h12345678); rsv(5'd0); rd(0, 5'd0);
        tick(); clear_inputs();
        check("x0_same_data", rd_data[31:0], 32'h0);
        check("x0_same_busy", 32'(rd_busy[0]), 32'h0);
        rd(0, 5'd0);
        tick(); clear_inputs();
        check("x0_later_data", rd_data[31:0], 32'h0);
        check("x0_later_busy", 32'(rd_busy[0]), 32'h0);

        // Scoreboard on x7.
        rsv(5'd7);
        tick(); clear_inputs();
        rd(1, 5'd7);
        tick(); clear_inputs();
        check("x7_rsv_busy", 32'(rd_busy[1]), 32'h1);
        check("x7_rsv_data", rd_data[63:32], 32'h0);
        wr(0, 5'd7, 32'h55); rsv(5'd7); rd(1, 5'd7);
        tick(); clear_inputs();
        check("x7_wr_rsv_byp_data", rd_data[63:32], 32'h55);
        check("x7_wr_rsv_byp_busy", 32'(rd_busy[1]), 32'h1);
        rd(0, 5'd7);
        tick(); clear_inputs();
        check("x7_wr_rsv_data", rd_data[31:0], 32'h55);
        check("x7_wr_rsv_busy", 32'(rd_busy[0]), 32'h1);
        wr(1, 5'd7, 32'h66); rd(0, 5'd7);
        tick(); clear_inputs();
        check("x7_clr_byp_data", rd_data[31:0], 32'h66);
        check("x7_clr_byp_busy", 32'(rd_busy[0]), 32'h0);
        rd(0, 5'd7);
        tick(); clear_inputs();
        check("x7_clr_data", rd_data[31:0], 32'h66);
        check("x7_clr_busy", 32'(rd_busy[0]), 32'h0);

        // Write conflict: the higher-numbered port wins.
        wr(0, 5'd9, 32'hA); wr(1, 5'd9, 32'hB); rd(0, 5'd9);
        tick(); clear_inputs();
        check("x9_conflict_byp", rd_data[31:0], 32'hB);
        rd(0, 5'd9); rd(1, 5'd9);
        tick(); clear_inputs();
        check("x9_conflict_p0", rd_data[31:0], 32'hB);
        check("x9_conflict_p1", rd_data[63:32], 32'hB);

        // Asynchronous reset pulse between reads of x4.
        wr(0, 5'd4, 32'h44);
        tick(); clear_inputs();
        rd(0, 5'd4);
        tick(); clear_inputs();
        check("x4_before_rst", rd_data[31:0], 32'h44);
        check("x4_valid_before", 32'(rd_valid[0]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(rd_valid), 32'h0);
        check("rst_async_data0", rd_data[31:0], 32'h0);
        #4 rst_n = 1'b1;
        rd(0, 5'd4);
        tick(); clear_inputs();
        check("x4_after_rst_valid", 32'(rd_valid[0]), 32'h1);
        check("x4_after_rst_data",  rd_data[31:0], 32'h0);
        tick();
        check("valid_drops", 32'(rd_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
